// File: rtl/rti_pkg.sv
// rti_pkg: shared register map, bit positions and event record for the
// rti_edge_stamper input path.
//   RTI_ADDR_*        : register addresses on the cs/read/write bus.
//   RTI_CTRL_*        : CTRL field positions.
//   RTI_STATUS_*      : STATUS field positions.
//   RTI_CMD_*         : CMD write bits.
//   rti_evt_t         : event record sized for the widest configuration;
//                       narrower builds zero-extend into it.
package rti_pkg;

    localparam int unsigned RTI_ADDR_W   = 5;
    localparam int unsigned RTI_DATA_W   = 32;
    localparam int unsigned RTI_MAX_IN   = 8;
    localparam int unsigned RTI_MAX_TS_W = 64;

    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_CTRL      = 5'd0;
    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_STATUS    = 5'd1;
    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_EVT_LO    = 5'd2;
    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_EVT_HI    = 5'd3;
    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_EVT_FLAGS = 5'd4;
    localparam logic [RTI_ADDR_W-1:0] RTI_ADDR_CMD       = 5'd5;

    localparam int unsigned RTI_CTRL_RISE_LSB = 0;
    localparam int unsigned RTI_CTRL_FALL_LSB = 8;
    localparam int unsigned RTI_CTRL_IRQ_EN   = 30;
    localparam int unsigned RTI_CTRL_RUN      = 31;

    localparam int unsigned RTI_STATUS_LEVEL_LSB = 0;
    localparam int unsigned RTI_STATUS_LEVEL_W   = 16;
    localparam int unsigned RTI_STATUS_EMPTY     = 16;
    localparam int unsigned RTI_STATUS_FULL      = 17;
    localparam int unsigned RTI_STATUS_OVF       = 18;
    localparam int unsigned RTI_STATUS_DROP_LSB  = 24;
    localparam int unsigned RTI_DROP_W           = 8;

    localparam int unsigned RTI_CMD_FLUSH    = 0;
    localparam int unsigned RTI_CMD_CLR_DROP = 1;

    localparam int unsigned RTI_FLAGS_VALID = 31;

    typedef struct packed {
        logic [RTI_MAX_IN-1:0]   fall_mask;
        logic [RTI_MAX_IN-1:0]   rise_mask;
        logic [RTI_MAX_TS_W-1:0] ts;
    } rti_evt_t;

    // EVT_FLAGS word: {valid, 15'b0, fall_mask, rise_mask}
    function automatic logic [RTI_DATA_W-1:0] rti_flags_word(input rti_evt_t evt,
                                                            input logic     valid);
        logic [RTI_DATA_W-1:0] w;
        w = '0;
        w[RTI_MAX_IN-1:0]              = evt.rise_mask;
        w[RTI_MAX_IN +: RTI_MAX_IN]    = evt.fall_mask;
        w[RTI_FLAGS_VALID]             = valid;
        return w;
    endfunction

endpackage

// File: rtl/rti_sync_fifo.sv
// rti_sync_fifo: single-clock FIFO, first-word-fall-through head.
//   clk_i, rst_i      : clock, asynchronous active-high reset.
//   push_i/push_data_i: write request; accepted when not full, or when full
//                       and a pop is accepted in the same cycle.
//   pop_i             : remove head; ignored when empty.
//   flush_i           : pointers and level to 0; overrides push and pop.
//   head_o            : current head entry (undefined when empty).
//   full_o, empty_o, level_o : registered occupancy.
//   empty_nxt_o       : empty flag as it will be after this edge.
module rti_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_nxt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i & ~empty_q & ~flush_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push_i & ~flush_i & (~full_q | pop_ok);

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array carries no reset; only occupied slots are ever read out.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign level_o     = cnt_q;
    assign empty_nxt_o = empty_d;

endmodule

// File: rtl/rti_edge_stamper.sv
// rti_edge_stamper: per-channel rising/falling edge detector that stamps
// each event with the free-running counter and queues it for the CPU bus.
//   clk, reset        : system clock, asynchronous active-high reset.
//   cs/read/write/addr/wr_data : register bus slave inputs.
//   rd_data           : registered read data, holds until the next read.
//   counter           : free-running timestamp (TS_W bits).
//   din               : asynchronous input pins (N_IN bits).
//   irq               : level, FIFO non-empty and CTRL.irq_en.
// Build option: define RTI_GLITCH_FILTER_EN to insert a FILTER_CYC-cycle
// stability filter between the synchroniser and the edge detector.
module rti_edge_stamper
    import rti_pkg::*;
#(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TS_W       = 64,
    parameter int unsigned FILTER_CYC = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  read,
    input  logic                  write,
    input  logic [RTI_ADDR_W-1:0] addr,
    input  logic [RTI_DATA_W-1:0] wr_data,
    output logic [RTI_DATA_W-1:0] rd_data,
    input  logic [TS_W-1:0]       counter,
    input  logic [N_IN-1:0]       din,
    output logic                  irq
);

    localparam int unsigned ENTRY_W = 2 * N_IN + TS_W;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Input synchroniser and previous-value flop
    // ------------------------------------------------------------------
    logic [N_IN-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IN-1:0] lvl_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= lvl_s;
        end
    end

`ifdef RTI_GLITCH_FILTER_EN
    // Filtered level follows the raw level only after FILTER_CYC
    // consecutive cycles of disagreement; the stamp is taken at that change.
    localparam int unsigned FILT_CNT_W = 4;

    logic [N_IN-1:0]       filt_q, filt_d;
    logic [FILT_CNT_W-1:0] filt_cnt_q [N_IN];
    logic [FILT_CNT_W-1:0] filt_cnt_d [N_IN];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            filt_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (filt_cnt_q[i] == FILT_CNT_W'(FILTER_CYC - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + FILT_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) filt_cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < int'(N_IN); i++) filt_cnt_q[i] <= filt_cnt_d[i];
        end
    end

    assign lvl_s = filt_q;
`else
    // Filter length is only meaningful when the filter is built in.
    logic [3:0] filter_cyc_unused;
    assign filter_cyc_unused = 4'(FILTER_CYC);
    assign lvl_s = sync2_q;
`endif

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic [N_IN-1:0]       rise_en_q, rise_en_d;
    logic [N_IN-1:0]       fall_en_q, fall_en_d;
    logic                  irq_en_q, irq_en_d;
    logic                  run_q, run_d;
    logic                  ovf_q, ovf_d;
    logic [RTI_DROP_W-1:0] drop_q, drop_d;
    rti_evt_t              shadow_q, shadow_d;
    logic                  shadow_vld_q, shadow_vld_d;
    logic [RTI_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  irq_q, irq_d;

    // Masked edge detect; events only exist while run is set
    logic [N_IN-1:0] rise_m, fall_m;
    logic            evt_any;

    assign rise_m  = lvl_s & ~prev_q & rise_en_q & {N_IN{run_q}};
    assign fall_m  = ~lvl_s & prev_q & fall_en_q & {N_IN{run_q}};
    assign evt_any = |{rise_m, fall_m};

    // Bus decode kept outside the register block to avoid a loop through the FIFO
    logic bus_rd, bus_wr, pop_req, flush_req, clr_drop;

    assign bus_rd    = cs & read;
    assign bus_wr    = cs & write;
    assign pop_req   = bus_rd & (addr == RTI_ADDR_EVT_LO);
    assign flush_req = bus_wr & (addr == RTI_ADDR_CMD) & wr_data[RTI_CMD_FLUSH];
    assign clr_drop  = bus_wr & (addr == RTI_ADDR_CMD) & wr_data[RTI_CMD_CLR_DROP];

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] head_raw;
    logic               fifo_full, fifo_empty, fifo_empty_nxt;
    logic [LVL_W-1:0]   fifo_level;
    rti_evt_t           head_evt;

    rti_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (evt_any),
        .push_data_i ({fall_m, rise_m, counter}),
        .pop_i       (pop_req),
        .flush_i     (flush_req),
        .head_o      (head_raw),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .empty_nxt_o (fifo_empty_nxt)
    );

    // Unpack the compact FIFO entry into the full-width event record
    always_comb begin
        head_evt           = '0;
        head_evt.ts        = RTI_MAX_TS_W'(head_raw[TS_W-1:0]);
        head_evt.rise_mask = RTI_MAX_IN'(head_raw[TS_W +: N_IN]);
        head_evt.fall_mask = RTI_MAX_IN'(head_raw[TS_W + N_IN +: N_IN]);
    end

    // Read-back words
    logic [RTI_DATA_W-1:0] ctrl_word, status_word;

    always_comb begin
        ctrl_word = '0;
        ctrl_word[RTI_CTRL_RISE_LSB +: RTI_MAX_IN] = RTI_MAX_IN'(rise_en_q);
        ctrl_word[RTI_CTRL_FALL_LSB +: RTI_MAX_IN] = RTI_MAX_IN'(fall_en_q);
        ctrl_word[RTI_CTRL_IRQ_EN]                 = irq_en_q;
        ctrl_word[RTI_CTRL_RUN]                    = run_q;

        status_word = '0;
        status_word[RTI_STATUS_LEVEL_LSB +: RTI_STATUS_LEVEL_W] = RTI_STATUS_LEVEL_W'(fifo_level);
        status_word[RTI_STATUS_EMPTY]                           = fifo_empty;
        status_word[RTI_STATUS_FULL]                            = fifo_full;
        status_word[RTI_STATUS_OVF]                             = ovf_q;
        status_word[RTI_STATUS_DROP_LSB +: RTI_DROP_W]          = drop_q;
    end

    logic bus_wr_unused;
    assign bus_wr_unused = ^wr_data;

    // Register next-state: bus writes, drop accounting, bus reads
    always_comb begin
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_en_d     = irq_en_q;
        run_d        = run_q;
        ovf_d        = ovf_q;
        drop_d       = drop_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        rd_data_d    = rd_data_q;

        if (bus_wr) begin
            case (addr)
                RTI_ADDR_CTRL: begin
                    rise_en_d = wr_data[RTI_CTRL_RISE_LSB +: N_IN];
                    fall_en_d = wr_data[RTI_CTRL_FALL_LSB +: N_IN];
                    irq_en_d  = wr_data[RTI_CTRL_IRQ_EN];
                    run_d     = wr_data[RTI_CTRL_RUN];
                end
                RTI_ADDR_STATUS: begin
                    if (wr_data[RTI_STATUS_OVF]) ovf_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (clr_drop) drop_d = '0;

        // A flushed event is lost silently; a pop in the same cycle makes room.
        if (evt_any && !flush_req && fifo_full && !pop_req) begin
            ovf_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + RTI_DROP_W'(1);
        end

        if (bus_rd) begin
            rd_data_d = '0;
            case (addr)
                RTI_ADDR_CTRL:   rd_data_d = ctrl_word;
                RTI_ADDR_STATUS: rd_data_d = status_word;
                RTI_ADDR_EVT_LO: begin
                    if (!fifo_empty) begin
                        rd_data_d    = head_evt.ts[RTI_DATA_W-1:0];
                        shadow_d     = head_evt;
                        shadow_vld_d = 1'b1;
                    end else begin
                        shadow_d     = '0;
                        shadow_vld_d = 1'b0;
                    end
                end
                RTI_ADDR_EVT_HI:    rd_data_d = RTI_DATA_W'(shadow_q.ts >> 32);
                RTI_ADDR_EVT_FLAGS: rd_data_d = rti_flags_word(shadow_q, shadow_vld_q);
                default: ;
            endcase
        end

        irq_d = irq_en_d & ~fifo_empty_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_en_q     <= 1'b0;
            run_q        <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            rd_data_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_en_q     <= irq_en_d;
            run_q        <= run_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            rd_data_q    <= rd_data_d;
            irq_q        <= irq_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule
